// File: rtl/par_to_serial_if.sv
// rtl/par_to_serial_if.sv - symbol-in / serial-out bundle for the TX serializer
interface par_to_serial_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             load;
  logic             serial_out;
  logic             byte_start;
  logic             sync_done;

  modport master (
    output data_in, in_valid,
    input  load, serial_out, byte_start, sync_done
  );

  modport slave (
    input  data_in, in_valid,
    output load, serial_out, byte_start, sync_done
  );
endinterface

// File: rtl/par_to_serial.sv
// rtl/par_to_serial.sv - MSB-first serializer with post-reset COMMA sync burst
module par_to_serial #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(8'hBC),
  parameter int               SYNC_COMMAS = 4
) (
  input  logic           dclk,
  input  logic           default_values,
  par_to_serial_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH);
  localparam int CCW  = (SYNC_COMMAS > 1) ? $clog2(SYNC_COMMAS) : 1;
  localparam logic [CNTW-1:0] LAST_BIT   = CNTW'(WIDTH - 1);
  localparam logic [CCW-1:0]  LAST_COMMA = CCW'(SYNC_COMMAS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNTW-1:0]  r_cnt;
  logic [CCW-1:0]   r_comma_cnt;
  logic             r_sync_done;

  state_t           w_next_state;
  logic             w_boundary;
  logic             w_data_rule;
  logic [WIDTH-1:0] w_next_sym;
  logic [WIDTH-1:0] w_next_shreg;
  logic [CNTW-1:0]  w_next_cnt;
  logic [CCW-1:0]   w_next_comma_cnt;
  logic             w_next_sync_done;

  always_comb begin
    w_next_state     = r_state;
    w_next_comma_cnt = r_comma_cnt;
    w_next_sync_done = r_sync_done;
    w_data_rule      = 1'b0;
    w_next_sym       = COMMA;
    w_boundary       = (r_state == S_IDLE) || (r_cnt == LAST_BIT);

    case (r_state)
      S_IDLE: begin
        w_next_state     = S_SYNC;
        w_next_comma_cnt = '0;
      end
      S_SYNC: begin
        // The final sync boundary already loads a data-rule symbol.
        if (w_boundary) begin
          if (r_comma_cnt == LAST_COMMA) begin
            w_data_rule      = 1'b1;
            w_next_state     = S_DATA;
            w_next_sync_done = 1'b1;
          end else begin
            w_next_comma_cnt = r_comma_cnt + CCW'(1);
          end
        end
      end
      S_DATA: w_data_rule = w_boundary;
      default: w_next_state = S_IDLE;
    endcase

    if (w_data_rule && bus.in_valid) begin
      w_next_sym = bus.data_in;
    end

    w_next_shreg = w_boundary ? w_next_sym : {r_shreg[WIDTH-2:0], 1'b0};
    w_next_cnt   = w_boundary ? '0 : r_cnt + CNTW'(1);
  end

  always_ff @(posedge dclk) begin
    if (default_values) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_comma_cnt <= '0;
      r_sync_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_shreg     <= w_next_shreg;
      r_cnt       <= w_next_cnt;
      r_comma_cnt <= w_next_comma_cnt;
      r_sync_done <= w_next_sync_done;
    end
  end

  assign bus.serial_out = r_shreg[WIDTH-1];
  assign bus.byte_start = (r_cnt == '0) && (r_state != S_IDLE);
  assign bus.sync_done  = r_sync_done;
  assign bus.load       = !default_values && w_data_rule;
endmodule

// File: tb/tb_par_to_serial.sv
// tb/tb_par_to_serial.sv - directed bench for par_to_serial (SYNC_COMMAS 4 and 1)
module tb_par_to_serial;
  localparam logic [7:0] COMMA = 8'hBC;

  logic dclk = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 dclk = ~dclk;

  par_to_serial_if #(.WIDTH(8)) bus ();
  par_to_serial_if #(.WIDTH(8)) bus2 ();

  par_to_serial #(.WIDTH(8), .COMMA(8'hBC), .SYNC_COMMAS(4)) dut (
    .dclk(dclk), .default_values(rst), .bus(bus)
  );

  par_to_serial #(.WIDTH(8), .COMMA(8'hBC), .SYNC_COMMAS(1)) dut2 (
    .dclk(dclk), .default_values(rst2), .bus(bus2)
  );

  function automatic logic bit_of(input logic [7:0] s, input int i);
    return s[7-i];
  endfunction

  task automatic next_cyc();
    @(posedge dclk);
    #1;
    cyc++;
  endtask

  task automatic start_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) @(posedge dclk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle 0 (IDLE) through cycle 32 (first load) with in_valid held low.
  task automatic run_sync_prefix(input string name);
    logic exp_bit;
    cyc = 0;
    #1;
    checks += 4;
    if (bus.serial_out !== 1'b0) begin failures++; $display("FAIL %s c0 serial_out got %b want 0", name, bus.serial_out); end
    if (bus.byte_start !== 1'b0) begin failures++; $display("FAIL %s c0 byte_start got %b want 0", name, bus.byte_start); end
    if (bus.load !== 1'b0) begin failures++; $display("FAIL %s c0 load got %b want 0", name, bus.load); end
    if (bus.sync_done !== 1'b0) begin failures++; $display("FAIL %s c0 sync_done got %b want 0", name, bus.sync_done); end
    for (int c = 1; c <= 32; c++) begin
      next_cyc();
      #2;
      exp_bit = bit_of(COMMA, (c - 1) % 8);
      checks += 4;
      if (bus.serial_out !== exp_bit) begin failures++; $display("FAIL %s c%0d serial_out got %b want %b", name, c, bus.serial_out, exp_bit); end
      if (bus.byte_start !== ((c - 1) % 8 == 0)) begin failures++; $display("FAIL %s c%0d byte_start got %b want %b", name, c, bus.byte_start, ((c - 1) % 8 == 0)); end
      if (bus.load !== (c == 32)) begin failures++; $display("FAIL %s c%0d load got %b want %b", name, c, bus.load, (c == 32)); end
      if (bus.sync_done !== 1'b0) begin failures++; $display("FAIL %s c%0d sync_done got %b want 0", name, c, bus.sync_done); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hFF;
    repeat (2) @(posedge dclk);
    #2;
    checks += 4;
    if (bus.serial_out !== 1'b0) begin failures++; $display("FAIL reset serial_out got %b want 0", bus.serial_out); end
    if (bus.byte_start !== 1'b0) begin failures++; $display("FAIL reset byte_start got %b want 0", bus.byte_start); end
    if (bus.load !== 1'b0) begin failures++; $display("FAIL reset load got %b want 0", bus.load); end
    if (bus.sync_done !== 1'b0) begin failures++; $display("FAIL reset sync_done got %b want 0", bus.sync_done); end
    start_reset();
    run_sync_prefix("sync");
    next_cyc();
    #2;
    checks += 3;
    if (bus.sync_done !== 1'b1) begin failures++; $display("FAIL sync c33 sync_done got %b want 1", bus.sync_done); end
    if (bus.byte_start !== 1'b1) begin failures++; $display("FAIL sync c33 byte_start got %b want 1", bus.byte_start); end
    if (bus.serial_out !== 1'b1) begin failures++; $display("FAIL sync c33 comma serial_out got %b want 1", bus.serial_out); end
  endtask

  task automatic test_single_symbol();
    start_reset();
    run_sync_prefix("single");
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hA5;
    for (int c = 33; c <= 41; c++) begin
      next_cyc();
      if (c == 33) begin bus.in_valid = 1'b0; bus.data_in = 8'h00; end
      #2;
      checks += 3;
      if (c <= 40 && bus.serial_out !== bit_of(8'hA5, c - 33)) begin failures++; $display("FAIL single c%0d serial_out got %b want %b", c, bus.serial_out, bit_of(8'hA5, c - 33)); end
      if (bus.byte_start !== (c == 33 || c == 41)) begin failures++; $display("FAIL single c%0d byte_start got %b want %b", c, bus.byte_start, (c == 33 || c == 41)); end
      if (bus.load !== (c == 40)) begin failures++; $display("FAIL single c%0d load got %b want %b", c, bus.load, (c == 40)); end
      if (bus.sync_done !== 1'b1) begin failures++; checks++; $display("FAIL single c%0d sync_done got %b want 1", c, bus.sync_done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] syms [3];
    syms[0] = 8'h00; syms[1] = 8'hFF; syms[2] = 8'h3C;
    start_reset();
    run_sync_prefix("b2b");
    bus.in_valid = 1'b1;
    bus.data_in  = syms[0];
    for (int c = 33; c <= 56; c++) begin
      next_cyc();
      if (c == 40) bus.data_in = syms[1];
      if (c == 48) bus.data_in = syms[2];
      if (c == 49) bus.in_valid = 1'b0;
      #2;
      checks += 2;
      if (bus.serial_out !== bit_of(syms[(c - 33) / 8], (c - 33) % 8)) begin failures++; $display("FAIL b2b c%0d serial_out got %b want %b", c, bus.serial_out, bit_of(syms[(c - 33) / 8], (c - 33) % 8)); end
      if (bus.load !== (c == 40 || c == 48 || c == 56)) begin failures++; $display("FAIL b2b c%0d load got %b want %b", c, bus.load, (c == 40 || c == 48 || c == 56)); end
    end
  endtask

  task automatic test_idle_gap();
    start_reset();
    run_sync_prefix("gap");
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hA5;
    for (int c = 33; c <= 48; c++) begin
      next_cyc();
      if (c == 40) begin bus.in_valid = 1'b0; bus.data_in = 8'h55; end
      if (c >= 41 && c <= 47) begin bus.data_in = 8'(c * 37); bus.in_valid = c[0]; end
      if (c == 48) bus.in_valid = 1'b0;
      #2;
      checks++;
      if (c <= 40) begin
        if (bus.serial_out !== bit_of(8'hA5, c - 33)) begin failures++; $display("FAIL gap c%0d serial_out got %b want %b", c, bus.serial_out, bit_of(8'hA5, c - 33)); end
      end else begin
        if (bus.serial_out !== bit_of(COMMA, c - 41)) begin failures++; $display("FAIL gap c%0d comma serial_out got %b want %b", c, bus.serial_out, bit_of(COMMA, c - 41)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    start_reset();
    run_sync_prefix("mid_pre");
    bus.in_valid = 1'b1;
    bus.data_in  = 8'hA5;
    for (int c = 33; c <= 36; c++) begin
      next_cyc();
      #2;
      checks++;
      if (bus.serial_out !== bit_of(8'hA5, c - 33)) begin failures++; $display("FAIL mid c%0d serial_out got %b want %b", c, bus.serial_out, bit_of(8'hA5, c - 33)); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.load !== 1'b0) begin failures++; $display("FAIL mid forced load got %b want 0", bus.load); end
    next_cyc();
    #2;
    checks += 4;
    if (bus.serial_out !== 1'b0) begin failures++; $display("FAIL mid serial_out got %b want 0", bus.serial_out); end
    if (bus.byte_start !== 1'b0) begin failures++; $display("FAIL mid byte_start got %b want 0", bus.byte_start); end
    if (bus.sync_done !== 1'b0) begin failures++; $display("FAIL mid sync_done got %b want 0", bus.sync_done); end
    if (bus.load !== 1'b0) begin failures++; $display("FAIL mid load got %b want 0", bus.load); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    run_sync_prefix("mid_resync");
  endtask

  task automatic test_sync1();
    logic exp_bit;
    rst2 = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.data_in  = 8'hF0;
    repeat (3) @(posedge dclk);
    #1;
    rst2 = 1'b0;
    cyc = 0;
    #1;
    checks += 2;
    if (bus2.serial_out !== 1'b0) begin failures++; $display("FAIL sync1 c0 serial_out got %b want 0", bus2.serial_out); end
    if (bus2.load !== 1'b0) begin failures++; $display("FAIL sync1 c0 load got %b want 0", bus2.load); end
    for (int c = 1; c <= 16; c++) begin
      next_cyc();
      #2;
      exp_bit = (c <= 8) ? bit_of(COMMA, c - 1) : bit_of(8'hF0, c - 9);
      checks += 4;
      if (bus2.serial_out !== exp_bit) begin failures++; $display("FAIL sync1 c%0d serial_out got %b want %b", c, bus2.serial_out, exp_bit); end
      if (bus2.load !== (c == 8 || c == 16)) begin failures++; $display("FAIL sync1 c%0d load got %b want %b", c, bus2.load, (c == 8 || c == 16)); end
      if (bus2.sync_done !== (c >= 9)) begin failures++; $display("FAIL sync1 c%0d sync_done got %b want %b", c, bus2.sync_done, (c >= 9)); end
      if (bus2.byte_start !== (c == 1 || c == 9)) begin failures++; $display("FAIL sync1 c%0d byte_start got %b want %b", c, bus2.byte_start, (c == 1 || c == 9)); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = 8'h00;
    bus2.in_valid = 1'b0;
    bus2.data_in  = 8'h00;
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_idle_gap();
    test_reset_mid();
    test_sync1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
